rfft_4pt_ctrl: RTL and testbench

RFFT_4PT_CTRL -- requirements
Module: rfft_4pt_ctrl

---
 rtl/rfft_4pt_ctrl.sv | 128 ++++++++++++
 tb/tb_rfft_4pt_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rfft_4pt_ctrl.sv
// Sequencer for a 4-point real-FFT datapath: a three-cycle schedule S1 -> S2A -> S2B, then DONE.
// Optional build macro RFFT_CTRL_INV_EN enables the inverse-transform (conjugate twiddle) request.
module rfft_4pt_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clr,
  input  logic        inv,
  output logic        ready,
  output logic        done,
  output logic        m0,
  output logic        m11,
  output logic        m14,
  output logic [1:0]  m12,
  output logic [1:0]  m13,
  output logic        m21,
  output logic        m22,
  output logic        m23,
  output logic        m24,
  output logic [15:0] w_r,
  output logic [15:0] w_i,
  output logic        en,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [2:0] {IDLE, S1, S2A, S2B, DONE} state_t;

  localparam logic [15:0] W_ONE     = 16'h4000;  // +1.0 in Q1.14
  localparam logic [15:0] W_ZERO    = 16'h0000;
  localparam logic [15:0] W_NEG_ONE = 16'hC000;  // -1.0 in Q1.14

  state_t state, next_state;
  logic   inv_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state gets a default first so no path through the case can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = S1;
      S1:      next_state = S2A;
      S2A:     next_state = S2B;
      S2B:     next_state = DONE;
      DONE:    next_state = start ? S1 : IDLE;
      default: next_state = IDLE;
    endcase
    if (clr) next_state = IDLE;
  end

  // Counts entries into DONE; an abort out of S2B must not count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     frame_cnt <= 8'd0;
    else if (state == S2B && !clr) frame_cnt <= frame_cnt + 8'd1;
  end

`ifdef RFFT_CTRL_INV_EN
  logic accept;
  assign accept = start && !clr && (state == IDLE || state == DONE);

  // inv is only sampled on acceptance so it stays fixed for the whole transform.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      inv_q <= 1'b0;
    else if (accept) inv_q <= inv;
  end
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign inv_q      = 1'b0;
`endif

  // Moore decode: every output depends on the current state only.
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    m0    = 1'b0;
    m11   = 1'b0;
    m12   = 2'd0;
    m13   = 2'd0;
    m14   = 1'b0;
    m21   = 1'b0;
    m22   = 1'b0;
    m23   = 1'b0;
    m24   = 1'b0;
    w_r   = W_ONE;
    w_i   = W_ZERO;
    en    = 1'b0;
    case (state)
      IDLE: ready = 1'b1;
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      S1: begin
        m12 = 2'd2;
        m13 = 2'd1;
        m14 = 1'b1;
        m23 = 1'b1;
        m24 = 1'b1;
        en  = 1'b1;
      end
      S2A: begin
        m0  = 1'b1;
        m12 = 2'd1;
        m13 = 2'd2;
        m14 = 1'b1;
        m23 = 1'b1;
        m24 = 1'b1;
        en  = 1'b1;
      end
      S2B: begin
        m0  = 1'b1;
        m11 = 1'b1;
        m21 = 1'b1;
        m22 = 1'b1;
        w_r = W_ZERO;
        w_i = inv_q ? W_ONE : W_NEG_ONE;
        en  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rfft_4pt_ctrl.sv
// Directed self-checking bench for rfft_4pt_ctrl; honours RFFT_CTRL_INV_EN for the twiddle expectation.
module tb_rfft_4pt_ctrl;

  localparam int ST_IDLE = 0, ST_S1 = 1, ST_S2A = 2, ST_S2B = 3, ST_DONE = 4;

  logic        clk, rst_n, start, clr, inv;
  logic        ready, done, m0, m11, m14, m21, m22, m23, m24, en;
  logic [1:0]  m12, m13;
  logic [15:0] w_r, w_i;
  logic [7:0]  frame_cnt;

  int vectors  = 0;
  int miscomps = 0;

  rfft_4pt_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .inv(inv),
    .ready(ready), .done(done), .m0(m0), .m11(m11), .m14(m14),
    .m12(m12), .m13(m13), .m21(m21), .m22(m22), .m23(m23), .m24(m24),
    .w_r(w_r), .w_i(w_i), .en(en), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word {m0,m11,m12,m13,m14,m21,m22,m23,m24,en,ready,done,w_r,w_i}.
  function automatic logic [45:0] expect_vec(input int st, input bit conj);
    case (st)
      ST_S1:   return {1'b0, 1'b0, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0000};
      ST_S2A:  return {1'b1, 1'b0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0000};
      ST_S2B:  return {1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000,
                       conj ? 16'h4000 : 16'hC000};
      ST_DONE: return {10'd0, 1'b1, 1'b1, 16'h4000, 16'h0000};
      default: return {10'd0, 1'b1, 1'b0, 16'h4000, 16'h0000};
    endcase
  endfunction

  function automatic logic [45:0] observed_vec();
    return {m0, m11, m12, m13, m14, m21, m22, m23, m24, en, ready, done, w_r, w_i};
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscomps++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_state(input string tag, input int st, input bit conj);
    check(tag, {18'd0, observed_vec()}, {18'd0, expect_vec(st, conj)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  bit inv_build;
  int dones;
  int last_done, gap_err;

  initial begin
`ifdef RFFT_CTRL_INV_EN
    inv_build = 1'b1;
`else
    inv_build = 1'b0;
`endif
    rst_n = 1'b1; start = 1'b0; clr = 1'b0; inv = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check_state("reset_outputs", ST_IDLE, 1'b0);
    check("reset_frame_cnt", {56'd0, frame_cnt}, 64'd0);
    #9 rst_n = 1'b1;

    // Single transform, start accepted at one edge.
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_state("single_s1", ST_S1, 1'b0);
    step(); check_state("single_s2a", ST_S2A, 1'b0);
    step(); check_state("single_s2b", ST_S2B, 1'b0);
    step(); check_state("single_done", ST_DONE, 1'b0);
    check("single_frame_cnt", {56'd0, frame_cnt}, 64'd1);
    step(); check_state("single_back_idle", ST_IDLE, 1'b0);

    // start held for 12 cycles: back-to-back transforms.
    pulse_reset();
    start = 1'b1;
    dones = 0; last_done = -1; gap_err = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) begin
        if (last_done >= 0 && i - last_done != 4) gap_err++;
        last_done = i;
        dones++;
      end
      if (i % 4 == 3) check_state("b2b_done_slot", ST_DONE, 1'b0);
    end
    start = 1'b0;
    check("b2b_done_count", 64'(dones), 64'd3);
    check("b2b_done_spacing", 64'(gap_err), 64'd0);
    check("b2b_frame_cnt", {56'd0, frame_cnt}, 64'd3);
    step(); check_state("b2b_idle", ST_IDLE, 1'b0);

    // Abort in S2A, then clr beating start in IDLE.
    start = 1'b1;
    step();
    start = 1'b0;
    step(); check_state("clr_in_s2a", ST_S2A, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_state("clr_to_idle", ST_IDLE, 1'b0);
    check("clr_frame_cnt", {56'd0, frame_cnt}, 64'd3);
    step(); check_state("clr_no_done", ST_IDLE, 1'b0);
    clr = 1'b1; start = 1'b1;
    step();
    clr = 1'b0; start = 1'b0;
    check_state("clr_beats_start", ST_IDLE, 1'b0);

    // Asynchronous reset in S2B.
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check_state("pre_reset_s2b", ST_S2B, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_state("async_reset_outputs", ST_IDLE, 1'b0);
    check("async_reset_frame_cnt", {56'd0, frame_cnt}, 64'd0);
    #2 rst_n = 1'b1;
    step(); check_state("post_reset_no_done", ST_IDLE, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_state("post_reset_accept", ST_S1, 1'b0);
    step(); step(); step();
    check("post_reset_frame_cnt", {56'd0, frame_cnt}, 64'd1);
    step();

    // 256 transforms: frame_cnt wraps to zero.
    pulse_reset();
    start = 1'b1;
    dones = 0;
    for (int i = 0; i < 1024; i++) begin
      step();
      if (done) dones++;
      if (i == 1019) check("wrap_cnt_255", {56'd0, frame_cnt}, 64'd255);
    end
    start = 1'b0;
    check("wrap_done_count", 64'(dones), 64'd256);
    check("wrap_cnt_0", {56'd0, frame_cnt}, 64'd0);
    step();

    // Inverse request captured at acceptance, then dropped during the transform.
    start = 1'b1; inv = 1'b1;
    step();
    start = 1'b0; inv = 1'b0;
    step(); step();
    check_state("inv_s2b_twiddle", ST_S2B, inv_build);
    step(); step();
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check_state("fwd_s2b_twiddle", ST_S2B, 1'b0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomps);
    $finish;
  end

endmodule
